// File: rtl/siganfu_pkg.sv
// Shared definitions for the turret fire arbiter: state encodings, station
// count, default limits and a one-hot to index helper.
package siganfu_pkg;

  localparam int unsigned NUM_STATIONS                 = 3;
  localparam int unsigned DEF_QUOTA                    = 10;
  localparam int unsigned DEF_MAX_HOLD_CYCLES          = 30;
  localparam int unsigned DEF_LOCKOUT_RELEASE_CYCLES   = 5;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_GRANT   = 3'd1,
    ARB_FIRING  = 3'd2,
    ARB_RELEASE = 3'd3,
    ARB_LOCKOUT = 3'd4
  } arb_state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_STATIONS-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_STATIONS; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/siganfu_rr_picker.sv
// Combinational round-robin picker: searches upward from the station after
// the pointer, wrapping 2 -> 0, and returns a one-hot winner (or zero).
module siganfu_rr_picker
  import siganfu_pkg::*;
(
  input  logic [2:0] eligible,
  input  logic [1:0] pointer,
  output logic [2:0] winner
);

  logic [1:0] ptr_c;
  logic [1:0] idx;

  always_comb begin
    winner = '0;
    idx    = '0;
    // Pointer value 3 is unreachable; treat it like 2 so station 0 goes first.
    ptr_c  = (pointer > 2'd2) ? 2'd2 : pointer;
    for (int unsigned k = 1; k <= NUM_STATIONS; k++) begin
      idx = 2'((32'(ptr_c) + k) % NUM_STATIONS);
      if (winner == '0 && eligible[idx]) winner[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/siganfu_turret_fire_arbiter.sv
// Turret fire arbiter: grants the gun to one of three operator stations,
// limits rounds/hold time per grant, and locks out on gun criticality alerts.
// Optional station-0 priority with preemption: define SIGANFU_ARB_PRIORITY_EN.
module siganfu_turret_fire_arbiter
  import siganfu_pkg::*;
#(
  parameter int unsigned QUOTA                  = DEF_QUOTA,
  parameter int unsigned MAX_HOLD_CYCLES        = DEF_MAX_HOLD_CYCLES,
  parameter int unsigned LOCKOUT_RELEASE_CYCLES = DEF_LOCKOUT_RELEASE_CYCLES
)(
  input  logic       sysclk,
  input  logic       reboot,
  input  logic [2:0] req,
  input  logic [2:0] req_mode,
  input  logic [2:0] req_target_locked,
  input  logic [2:0] req_is_enemy,
  input  logic       gun_criticality_alert,
  input  logic       gun_fire_trigger,
  output logic       target_locked,
  output logic       is_enemy,
  output logic       firing_mode,
  output logic       fire_command,
  output logic [2:0] grant,
  output logic [2:0] arb_state,
  output logic       grant_done,
  output logic       lockout
);

  localparam int unsigned RW = $clog2(QUOTA) + 1;
  localparam int unsigned HW = $clog2(MAX_HOLD_CYCLES) + 1;
  localparam int unsigned LW = $clog2(LOCKOUT_RELEASE_CYCLES) + 1;

  arb_state_t    state, state_n;
  logic [2:0]    grant_n;
  logic          tl_n, ie_n, fm_n, fire_n, done_n, lockout_n;
  logic [1:0]    ptr, ptr_n;
  logic [RW-1:0] rounds, rounds_n, round_limit;
  logic [HW-1:0] hold, hold_n;
  logic [LW-1:0] quiet, quiet_n;
  logic          trig_prev, trig_rise, holder_ok, go_release, preempt;
  logic [2:0]    eligible, rr_winner, winner;

  assign eligible    = req & req_target_locked & req_is_enemy;
  assign trig_rise   = gun_fire_trigger & ~trig_prev;
  assign holder_ok   = |(grant & eligible);
  assign round_limit = firing_mode ? RW'(QUOTA) : RW'(1);
  assign arb_state   = state;

  siganfu_rr_picker u_picker (
    .eligible (eligible),
    .pointer  (ptr),
    .winner   (rr_winner)
  );

`ifdef SIGANFU_ARB_PRIORITY_EN
  assign winner  = eligible[0] ? 3'b001 : rr_winner;
  assign preempt = eligible[0] & ~grant[0];
`else
  assign winner  = rr_winner;
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    tl_n       = target_locked;
    ie_n       = is_enemy;
    fm_n       = firing_mode;
    fire_n     = 1'b0;
    done_n     = 1'b0;
    ptr_n      = ptr;
    rounds_n   = rounds;
    hold_n     = hold;
    quiet_n    = '0;
    go_release = 1'b0;

    case (state)
      ARB_IDLE: begin
        if (|eligible) begin
          state_n  = ARB_GRANT;
          grant_n  = winner;
          tl_n     = |(winner & req_target_locked);
          ie_n     = |(winner & req_is_enemy);
          fm_n     = |(winner & req_mode);
          rounds_n = '0;
          hold_n   = '0;
        end
      end
      ARB_GRANT: begin
        if (holder_ok) begin
          state_n = ARB_FIRING;
          fire_n  = 1'b1;
        end else begin
          go_release = 1'b1;
        end
      end
      ARB_FIRING: begin
        rounds_n = (rounds == '1) ? rounds : rounds + RW'(trig_rise);
        hold_n   = (hold == '1) ? hold : hold + 1'b1;
        if (!holder_ok || rounds_n >= round_limit ||
            hold_n >= HW'(MAX_HOLD_CYCLES) || preempt) begin
          go_release = 1'b1;
        end else begin
          fire_n = 1'b1;
        end
      end
      ARB_RELEASE: state_n = ARB_IDLE;
      ARB_LOCKOUT: begin
        if (!gun_criticality_alert) begin
          if (32'(quiet) + 32'd1 >= LOCKOUT_RELEASE_CYCLES) state_n = ARB_IDLE;
          else quiet_n = quiet + 1'b1;
        end
      end
      default: state_n = ARB_IDLE;
    endcase

    if (go_release) begin
      state_n = ARB_RELEASE;
      done_n  = 1'b1;
      ptr_n   = onehot_to_idx(grant);
    end

    // The alert outranks every exit path decided above, including a release.
    if (gun_criticality_alert && state != ARB_LOCKOUT) begin
      state_n = ARB_LOCKOUT;
      quiet_n = '0;
      done_n  = (state == ARB_GRANT) || (state == ARB_FIRING);
      ptr_n   = done_n ? onehot_to_idx(grant) : ptr;
    end

    if (state_n != ARB_GRANT && state_n != ARB_FIRING) begin
      grant_n = '0;
      tl_n    = 1'b0;
      ie_n    = 1'b0;
      fm_n    = 1'b0;
      fire_n  = 1'b0;
    end
    lockout_n = (state_n == ARB_LOCKOUT);
  end

  always_ff @(posedge sysclk) begin
    if (reboot) begin
      state         <= ARB_IDLE;
      grant         <= '0;
      target_locked <= 1'b0;
      is_enemy      <= 1'b0;
      firing_mode   <= 1'b0;
      fire_command  <= 1'b0;
      grant_done    <= 1'b0;
      lockout       <= 1'b0;
      ptr           <= 2'd2;
      rounds        <= '0;
      hold          <= '0;
      quiet         <= '0;
      trig_prev     <= 1'b0;
    end else begin
      state         <= state_n;
      grant         <= grant_n;
      target_locked <= tl_n;
      is_enemy      <= ie_n;
      firing_mode   <= fm_n;
      fire_command  <= fire_n;
      grant_done    <= done_n;
      lockout       <= lockout_n;
      ptr           <= ptr_n;
      rounds        <= rounds_n;
      hold          <= hold_n;
      quiet         <= quiet_n;
      trig_prev     <= gun_fire_trigger;
    end
  end

endmodule

// File: tb/tb_siganfu_turret_fire_arbiter.sv
// Self-checking bench for siganfu_turret_fire_arbiter: a per-cycle reference
// model plus directed scenarios with hand-computed expectations (1 time unit = 1 ms).
module tb_siganfu_turret_fire_arbiter;

  localparam int HALF_CLOCK_CYCLE = 5;
  localparam int QUOTA_P = 10;
  localparam int HOLD_P  = 30;
  localparam int LRC_P   = 5;

  logic       sysclk, reboot;
  logic [2:0] req, req_mode, req_target_locked, req_is_enemy;
  logic       gun_criticality_alert, gun_fire_trigger;
  logic       target_locked, is_enemy, firing_mode, fire_command;
  logic [2:0] grant, arb_state;
  logic       grant_done, lockout;

  int total = 0;
  int bad = 0;
  int done_seen = 0;

  siganfu_turret_fire_arbiter #(
    .QUOTA                  (QUOTA_P),
    .MAX_HOLD_CYCLES        (HOLD_P),
    .LOCKOUT_RELEASE_CYCLES (LRC_P)
  ) dut (
    .sysclk                (sysclk),
    .reboot                (reboot),
    .req                   (req),
    .req_mode              (req_mode),
    .req_target_locked     (req_target_locked),
    .req_is_enemy          (req_is_enemy),
    .gun_criticality_alert (gun_criticality_alert),
    .gun_fire_trigger      (gun_fire_trigger),
    .target_locked         (target_locked),
    .is_enemy              (is_enemy),
    .firing_mode           (firing_mode),
    .fire_command          (fire_command),
    .grant                 (grant),
    .arb_state             (arb_state),
    .grant_done            (grant_done),
    .lockout               (lockout)
  );

  // First rising edge at t=2 so the 3 ms power-on reboot is sampled.
  initial begin
    sysclk = 1'b0;
    #2;
    forever begin
      sysclk = 1'b1;
      #HALF_CLOCK_CYCLE;
      sysclk = 1'b0;
      #HALF_CLOCK_CYCLE;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
    end
  endtask

  // Reference model: station index, phase number and plain integer counters.
  initial begin : scoreboard
    int st, owner, ptr, rounds, hold, quiet, nxt;
    bit auto_m, prev, rise, pulse, rel, busy;
    bit [2:0] el;
    logic [11:0] expv, gotv;
    st = 0; owner = -1; ptr = 2; rounds = 0; hold = 0; quiet = 0; auto_m = 0; prev = 0;
    forever begin
      @(posedge sysclk);
      el    = req & req_target_locked & req_is_enemy;
      rise  = gun_fire_trigger && !prev;
      prev  = gun_fire_trigger;
      pulse = 0;
      rel   = 0;
      if (reboot) begin
        st = 0; owner = -1; ptr = 2; rounds = 0; hold = 0; quiet = 0; prev = 0;
      end else if (gun_criticality_alert && st != 4) begin
        if (st == 1 || st == 2) begin pulse = 1; ptr = owner; end
        st = 4; quiet = 0;
      end else begin
        case (st)
          0: begin
            nxt = -1;
            for (int k = 1; k <= 3; k++)
              if (nxt < 0 && el[(ptr + k) % 3]) nxt = (ptr + k) % 3;
`ifdef SIGANFU_ARB_PRIORITY_EN
            if (el[0]) nxt = 0;
`endif
            if (nxt >= 0) begin
              owner = nxt; auto_m = req_mode[nxt]; rounds = 0; hold = 0; st = 1;
            end
          end
          1: if (!el[owner]) rel = 1; else st = 2;
          2: begin
            rounds += int'(rise);
            hold++;
            if (!el[owner] || rounds >= (auto_m ? QUOTA_P : 1) || hold >= HOLD_P) rel = 1;
`ifdef SIGANFU_ARB_PRIORITY_EN
            if (owner != 0 && el[0]) rel = 1;
`endif
          end
          3: st = 0;
          4: begin
            quiet = gun_criticality_alert ? 0 : quiet + 1;
            if (quiet >= LRC_P) begin st = 0; quiet = 0; end
          end
          default: st = 0;
        endcase
        if (rel) begin st = 3; pulse = 1; ptr = owner; end
      end
      #1;
      busy = (st == 1 || st == 2);
      expv = {busy ? 3'(1 << owner) : 3'b000, 3'(st), st == 2, busy, busy,
              busy && auto_m, pulse, st == 4};
      gotv = {grant, arb_state, fire_command, target_locked, is_enemy,
              firing_mode, grant_done, lockout};
      check("cycle", 32'(gotv), 32'(expv));
      if (grant_done === 1'b1) done_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic set_station(input int s, input bit on, input bit mode);
    req[s] = on; req_target_locked[s] = on; req_is_enemy[s] = on; req_mode[s] = mode;
  endtask

  task automatic clear_inputs();
    req = '0; req_mode = '0; req_target_locked = '0; req_is_enemy = '0;
    gun_criticality_alert = 1'b0; gun_fire_trigger = 1'b0;
  endtask

  task automatic reboot_pulse();
    clear_inputs();
    reboot = 1'b1;
    tick(1);
    reboot = 1'b0;
    check("reboot_state", arb_state, 3'd0);
  endtask

  task automatic wait_state(input logic [2:0] s, input string nm);
    int n = 0;
    while (arb_state !== s && n < 60) begin tick(1); n++; end
    check(nm, arb_state, s);
  endtask

  initial begin : stimulus
    logic [2:0] exp_b [4];
    int fcount;
    exp_b = '{3'b001, 3'b010, 3'b100, 3'b001};
    clear_inputs();
    reboot = 1'b1;
    #3 reboot = 1'b0;
    @(negedge sysclk);
    check("reset_outputs", {grant, arb_state, fire_command, target_locked,
                            is_enemy, firing_mode, grant_done, lockout}, 0);

    // Station 1 auto, ten trigger edges.
    done_seen = 0;
    set_station(1, 1'b1, 1'b1);
    tick(1);
    check("a_grant", grant, 3'b010);
    check("a_fire_in_grant", fire_command, 1'b0);
    check("a_mode", firing_mode, 1'b1);
    tick(1);
    check("a_fire_on", fire_command, 1'b1);
    for (int k = 0; k < 10; k++) begin
      gun_fire_trigger = 1'b1;
      tick(1);
      if (k == 9) begin
        check("a_release", arb_state, 3'd3);
        check("a_done", grant_done, 1'b1);
        set_station(1, 1'b0, 1'b0);
      end else begin
        check("a_still_firing", arb_state, 3'd2);
      end
      gun_fire_trigger = 1'b0;
      tick(1);
    end
    tick(2);
    check("a_done_count", done_seen, 1);

    // Round-robin over three single-mode stations.
    reboot_pulse();
    for (int s = 0; s < 3; s++) set_station(s, 1'b1, 1'b0);
    for (int g = 0; g < 4; g++) begin
      wait_state(3'd1, "b_wait_grant");
      check("b_grant_order", grant, exp_b[g]);
      wait_state(3'd2, "b_wait_fire");
      gun_fire_trigger = 1'b1;
      tick(1);
      gun_fire_trigger = 1'b0;
    end
    clear_inputs();
    tick(3);

    // Alert mid-FIRING for three cycles.
    reboot_pulse();
    set_station(0, 1'b1, 1'b1);
    wait_state(3'd2, "c_wait_fire");
    gun_criticality_alert = 1'b1;
    tick(1);
    check("c_lock_state", arb_state, 3'd4);
    check("c_lock_fire", fire_command, 1'b0);
    check("c_lock_flag", lockout, 1'b1);
    check("c_lock_done", grant_done, 1'b1);
    tick(2);
    gun_criticality_alert = 1'b0;
    set_station(0, 1'b0, 1'b0);
    tick(4);
    check("c_still_locked", arb_state, 3'd4);
    tick(1);
    check("c_exit_idle", arb_state, 3'd0);

    // Hold limit with no trigger edges.
    reboot_pulse();
    set_station(2, 1'b1, 1'b1);
    wait_state(3'd2, "d_wait_fire");
    fcount = 1;
    for (int n = 0; n < 100; n++) begin
      tick(1);
      if (arb_state !== 3'd2) break;
      fcount++;
    end
    check("d_fire_cycles", fcount, HOLD_P);
    check("d_release", arb_state, 3'd3);
    set_station(2, 1'b0, 1'b0);
    tick(2);

    // Enemy flag dropped during GRANT.
    set_station(1, 1'b1, 1'b1);
    wait_state(3'd1, "d_wait_grant");
    req_is_enemy[1] = 1'b0;
    tick(1);
    check("d_no_fire_state", arb_state, 3'd3);
    check("d_no_fire_cmd", fire_command, 1'b0);
    clear_inputs();
    tick(2);

    // reboot mid-FIRING.
    reboot_pulse();
    set_station(1, 1'b1, 1'b1);
    wait_state(3'd2, "e_wait_fire");
    reboot = 1'b1;
    tick(1);
    check("e_reboot_outputs", {grant, arb_state, fire_command, target_locked,
                               is_enemy, firing_mode, grant_done, lockout}, 0);
    reboot = 1'b0;

    // Station 0 request during a station-2 grant.
    clear_inputs();
    set_station(2, 1'b1, 1'b1);
    wait_state(3'd2, "e_wait_fire2");
    set_station(0, 1'b1, 1'b1);
    tick(1);
`ifdef SIGANFU_ARB_PRIORITY_EN
    check("e_preempt_release", arb_state, 3'd3);
    check("e_preempt_grant0", grant, 3'b000);
    tick(2);
    check("e_priority_grant", grant, 3'b001);
`else
    check("e_no_preempt_state", arb_state, 3'd2);
    check("e_no_preempt_grant", grant, 3'b100);
`endif
    clear_inputs();
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/siganfu_turret_fire_arbiter.md
SIGANFU_TURRET_FIRE_ARBITER -- requirements
Module: siganfu_turret_fire_arbiter

Interface
REQ-001 SHALL have parameter QUOTA, default 10, the maximum number of rounds per auto-mode grant.
REQ-002 SHALL have parameter MAX_HOLD_CYCLES, default 30, the maximum number of FIRING cycles per grant.
REQ-003 SHALL have parameter LOCKOUT_RELEASE_CYCLES, default 5, the number of consecutive alert-free cycles needed to leave LOCKOUT.
REQ-004 SHALL have port sysclk  input  1  the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port reboot  input  1  the reset: synchronous, active-high.
REQ-006 SHALL have port req  input  3  fire request from each of operator stations 0..2.
REQ-007 SHALL have port req_mode  input  3  requested mode per station: 1 = auto, 0 = single.
REQ-008 SHALL have port req_target_locked  input  3  target-locked flag per station.
REQ-009 SHALL have port req_is_enemy  input  3  enemy identification per station.
REQ-010 SHALL have port gun_criticality_alert  input  1  criticality alert returned by the gun.
REQ-011 SHALL have port gun_fire_trigger  input  1  fire trigger returned by the gun; each rising edge is one round.
REQ-012 SHALL have port target_locked, is_enemy, firing_mode, fire_command  output  1 each  registered drives into the gun.
REQ-013 SHALL have port grant  output  3  one-hot or zero; identifies the station that owns the gun.
REQ-014 SHALL have port arb_state  output  3  current state encoding.
REQ-015 SHALL have port grant_done  output  1  one-cycle pulse marking the end of a grant.
REQ-016 SHALL have port lockout  output  1  high while in LOCKOUT.

Function
REQ-017 Station i SHALL be eligible only when req[i], req_target_locked[i] and req_is_enemy[i] are all high.
REQ-018 States SHALL be encoded IDLE=0, GRANT=1, FIRING=2, RELEASE=3, LOCKOUT=4; values 5..7 SHALL go to IDLE.
REQ-019 IDLE: if any station is eligible at edge k, the next state SHALL be GRANT at k+1.
REQ-020 Winner selection SHALL be round-robin, searching upward from the station after the pointer and wrapping 2->0.
REQ-021 GRANT SHALL last one cycle with grant, target_locked, is_enemy and firing_mode taken from the winner and fire_command=0.
REQ-022 FIRING SHALL be entered at k+2 with fire_command=1.
REQ-023 In FIRING the block SHALL count rising edges of gun_fire_trigger, detected against a registered copy of the previous value.
REQ-024 The round limit SHALL be 1 for single mode and QUOTA for auto mode.
REQ-025 FIRING SHALL exit to RELEASE when any of these holds: the granted station becomes ineligible; the round count reaches the limit; the hold counter reaches MAX_HOLD_CYCLES.
REQ-026 RELEASE SHALL last one cycle with fire_command=0 and grant=0, pulse grant_done, set the pointer to the granted station, then go to IDLE.
REQ-027 A station that becomes ineligible during GRANT SHALL cause RELEASE instead of FIRING.
REQ-028 While in GRANT or FIRING, requests from other stations SHALL be ignored; there is no preemption unless the macro in REQ-036 is defined.
REQ-029 gun_criticality_alert high in any state other than LOCKOUT SHALL force LOCKOUT on the next edge, with all gun drives and grant at 0.
REQ-030 Entering LOCKOUT SHALL pulse grant_done only if a grant was active, and SHALL set the pointer to the interrupted station.
REQ-031 LOCKOUT SHALL exit to IDLE after LOCKOUT_RELEASE_CYCLES consecutive cycles with the alert low; any alert high restarts the count.
REQ-032 An alert arriving on the same edge as a FIRING exit condition SHALL take priority (LOCKOUT, not RELEASE).
REQ-033 The round counter and hold counter SHALL be sized by $clog2 of their limit plus 1, SHALL saturate, and SHALL clear when GRANT is entered.

Reset
REQ-034 reboot high at a clock edge SHALL set state=IDLE, all outputs 0, pointer=2 (so station 0 is searched first), all counters 0 and the trigger-history register 0.
REQ-035 reboot SHALL override every other input, including when asserted mid-FIRING or mid-LOCKOUT.

Configuration
REQ-036 When SIGANFU_ARB_PRIORITY_EN is defined, an eligible station 0 SHALL always win in IDLE, and SHALL force a non-zero holder's FIRING grant to RELEASE on the next edge.
REQ-037 When SIGANFU_ARB_PRIORITY_EN is not defined, arbitration SHALL be pure round-robin with no preemption.

Structure
REQ-038 A shared package siganfu_pkg SHALL hold the state encodings, the station count (3) and the default parameter values.
REQ-039 Round-robin selection SHALL be a combinational sub-module siganfu_rr_picker with inputs eligible[2:0] and pointer[1:0], and output winner one-hot.

Verification
REQ-040 Bench SHALL use a 10 ms clock period (HALF_CLOCK_CYCLE=5) and a 3 ms reboot at start.
REQ-041 Station 1 eligible, auto, 10 trigger edges -> grant=010, fire_command high 2 cycles after req; RELEASE after the 10th edge; grant_done one pulse.
REQ-042 Stations 0, 1, 2 eligible continuously, single mode, one trigger per grant -> grants in order 001, 010, 100, 001.
REQ-043 Alert raised mid-FIRING for 3 cycles -> LOCKOUT next edge, fire_command=0, lockout high; IDLE exactly 5 cycles after the alert falls.
REQ-044 Auto grant with no trigger edges -> RELEASE after 30 FIRING cycles; req_is_enemy dropped during GRANT -> RELEASE with no FIRING cycle.
REQ-045 reboot mid-FIRING -> all outputs 0 next edge; with the macro defined, station 0 requesting during a station-2 grant -> station 2 released next edge, then grant=001.
